// File: rtl/sprite_ram_writer.sv
// Sprite loader: turns a row-major pixel stream into addressed writes for the
// sprite RAM, using the mapper's layout addr = PITCH*y + x.
//
// state | meaning
// IDLE  | waiting for start; validates the requested rectangle
// RUN   | accepting pixels, one registered write per accepted beat
// FLUSH | last write visible on the RAM port
// DONE  | one-cycle done pulse, then back to IDLE
module sprite_ram_writer #(
    parameter int                ADDR_W = 15,
    parameter int                DATA_W = 32,
    parameter int                PITCH  = 128,
    parameter logic [DATA_W-1:0] KEY    = 32'h00FF0000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [9:0]        org_x,
    input  logic [9:0]        org_y,
    input  logic [9:0]        width,
    input  logic [9:0]        height,
    input  logic              skip_key,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0]       PITCH_L  = 32'(PITCH);
    localparam logic [31:0]       ADDR_MAX = (32'd1 << ADDR_W) - 32'd1;
    localparam logic [ADDR_W-1:0] PITCH_A  = ADDR_W'(PITCH);

    state_t state_q, state_d;

    logic [9:0]        col_q, col_d;
    logic [9:0]        row_q, row_d;
    logic [9:0]        width_q, width_d;
    logic [9:0]        height_q, height_d;
    logic              skip_q, skip_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic [31:0]       ox_w, oy_w, w_w, h_w;
    logic [31:0]       right_edge, last_row, last_addr;
    logic [ADDR_W-1:0] base_start;
    logic              req_ok;

    logic beat, last_col, last_line, final_beat;

    // Request validation in 32-bit unsigned so no term can wrap before the compare.
    always_comb begin
        ox_w       = 32'(org_x);
        oy_w       = 32'(org_y);
        w_w        = 32'(width);
        h_w        = 32'(height);
        right_edge = ox_w + w_w;
        last_row   = oy_w + h_w - 32'd1;
        last_addr  = PITCH_L * last_row + right_edge - 32'd1;
        base_start = ADDR_W'(PITCH_L * oy_w + ox_w);
        req_ok     = (width != 10'd0) && (height != 10'd0) &&
                     (right_edge <= PITCH_L) && (last_addr <= ADDR_MAX);
    end

    always_comb begin
        beat       = in_valid && in_ready_q;
        last_col   = (col_q == width_q - 10'd1);
        last_line  = (row_q == height_q - 10'd1);
        final_beat = beat && last_col && last_line;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && req_ok) state_d = ST_RUN;
            ST_RUN:   if (final_beat) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        done = (state_q == ST_DONE);
    end

    // Ready is registered: it rises one cycle into RUN and drops right after the final beat.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        width_d    = width_q;
        height_d   = height_q;
        skip_d     = skip_q;
        base_d     = base_q;
        in_ready_d = 1'b0;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;

        if (state_q == ST_IDLE && start) begin
            if (req_ok) begin
                width_d  = width;
                height_d = height;
                skip_d   = skip_key;
                base_d   = base_start;
                col_d    = 10'd0;
                row_d    = 10'd0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (state_q == ST_RUN) begin
            in_ready_d = !final_beat;
            if (beat) begin
                we_d    = !(skip_q && (in_data == KEY));
                waddr_d = base_q + ADDR_W'(col_q);
                wdata_d = in_data;
                if (last_col) begin
                    col_d  = 10'd0;
                    row_d  = row_q + 10'd1;
                    base_d = base_q + PITCH_A;
                end else begin
                    col_d = col_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            skip_q     <= 1'b0;
            base_q     <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            width_q    <= width_d;
            height_q   <= height_d;
            skip_q     <= skip_d;
            base_q     <= base_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Bench for sprite_ram_writer: directed scenarios plus randomized rectangles,
// checked every cycle against a pixel-index model of the transfer.
module tb_sprite_ram_writer;

    localparam int          ADDR_W = 15;
    localparam int          DATA_W = 32;
    localparam int          PITCH  = 128;
    localparam logic [31:0] KEY    = 32'h00FF0000;

    localparam int P_IDLE = 0, P_RUN = 1, P_FLUSH = 2, P_DONE = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [9:0]        org_x = '0, org_y = '0, width = '0, height = '0;
    logic              skip_key = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, we, busy, done, err;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    always #5 clk = ~clk;

    sprite_ram_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PITCH(PITCH), .KEY(KEY)) dut (
        .Clk(clk), .Reset_n(rst_n), .start(start), .org_x(org_x), .org_y(org_y),
        .width(width), .height(height), .skip_key(skip_key), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .we(we), .waddr(waddr),
        .wdata(wdata), .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit req_valid(input int ox, input int oy, input int w, input int h);
        if (w == 0 || h == 0) return 1'b0;
        if (ox + w > PITCH) return 1'b0;
        if (PITCH * (oy + h - 1) + ox + w - 1 > (1 << ADDR_W) - 1) return 1'b0;
        return 1'b1;
    endfunction

    // Model: tracks pixels accepted (m_k) and derives each address from the pixel index.
    int          m_phase = P_IDLE;
    bit          m_ready = 0, m_we = 0, m_err = 0, m_busy = 0, m_done = 0;
    int          m_waddr = 0;
    logic [31:0] m_wdata = '0;
    int          m_ox = 0, m_oy = 0, m_w = 1, m_h = 1, m_k = 0;
    bit          m_skip = 0;
    bit          m_beat;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_ready = 0; m_we = 0; m_err = 0;
            m_waddr = 0; m_wdata = '0; m_k = 0;
        end else begin
            m_beat = m_ready && in_valid;
            m_we = 0;
            m_err = 0;
            if (m_beat) begin
                m_we    = !(m_skip && in_data == KEY);
                m_waddr = PITCH * (m_oy + m_k / m_w) + m_ox + m_k % m_w;
                m_wdata = in_data;
                m_k++;
            end
            case (m_phase)
                P_IDLE: begin
                    m_ready = 0;
                    if (start) begin
                        if (req_valid(int'(org_x), int'(org_y), int'(width), int'(height))) begin
                            m_ox = org_x; m_oy = org_y; m_w = width; m_h = height;
                            m_skip = skip_key; m_k = 0; m_phase = P_RUN;
                        end else begin
                            m_err = 1;
                        end
                    end
                end
                P_RUN: begin
                    if (m_k == m_w * m_h) begin
                        m_phase = P_FLUSH;
                        m_ready = 0;
                    end else begin
                        m_ready = 1;
                    end
                end
                P_FLUSH: m_phase = P_DONE;
                default: m_phase = P_IDLE;
            endcase
        end
        m_busy = (m_phase == P_RUN) || (m_phase == P_FLUSH);
        m_done = (m_phase == P_DONE);
    end

    int          wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          done_cnt = 0, err_cnt = 0, done_cyc = 0;
    int          busy_first = 0, busy_last = 0;
    bit          busy_prev = 0;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("in_ready", in_ready, m_ready);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("we", we, m_we);
            if (m_we) begin
                chk("waddr", waddr, m_waddr);
                chk("wdata", wdata, m_wdata);
            end
            if (we) begin
                wq_addr.push_back(int'(waddr));
                wq_data.push_back(wdata);
                wq_cyc.push_back(cyc);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
            if (busy && !busy_prev) busy_first = cyc;
            if (!busy && busy_prev) busy_last = cyc - 1;
            busy_prev = busy;
        end else begin
            busy_prev = 0;
        end
    end

    logic [31:0] pix[0:255];

    task automatic clear_log();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    endtask

    task automatic do_start(input int ox, input int oy, input int w, input int h, input bit sk);
        @(negedge clk);
        start = 1'b1;
        org_x = 10'(ox); org_y = 10'(oy); width = 10'(w); height = 10'(h);
        skip_key = sk;
    endtask

    // mode 0: valid always; 1: valid alternates 1-0 on ready cycles; 2: random, junk when not ready
    task automatic stream(input int n, input int mode, input int abort_at, input int restart_at);
        int i = 0;
        int t = 0;
        bit ph = 1;
        bit v;
        bit restarted = 0;
        while (i < n && t < 3000) begin
            if (i == abort_at) return;
            @(negedge clk);
            t++;
            start = 1'b0;
            if (i == restart_at && !restarted) begin
                restarted = 1;
                start = 1'b1;
                org_x = 10'd50; org_y = 10'd9; width = 10'd2; height = 10'd2;
            end
            if (mode == 0) v = 1;
            else if (mode == 1) begin
                v = in_ready ? ph : 1'b0;
                if (in_ready) ph = !ph;
            end else v = 1'($urandom_range(0, 1));
            in_valid = v;
            if (v && in_ready) begin
                in_data = pix[i];
                i++;
            end else begin
                in_data = $urandom;
            end
        end
        if (i < n) begin
            errors++;
            $display("FAIL stream_timeout accepted=%0d required=%0d", i, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_phase == P_IDLE && !busy) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout busy=%0b required=0", busy);
        end
    endtask

    int s, d0, e0, n;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // continuous 2x2 at origin
        clear_log();
        pix[0] = 32'h00A0A0A0; pix[1] = 32'h00B0B0B0; pix[2] = 32'h00C0C0C0; pix[3] = 32'h00D0D0D0;
        do_start(0, 0, 2, 2, 0);
        s = cyc;
        stream(4, 0, -1, -1);
        wait_idle();
        chk("t2_nwr", wq_addr.size(), 4);
        if (wq_addr.size() == 4) begin
            chk("t2_a0", wq_addr[0], 0);   chk("t2_d0", wq_data[0], 32'h00A0A0A0);
            chk("t2_a1", wq_addr[1], 1);   chk("t2_d1", wq_data[1], 32'h00B0B0B0);
            chk("t2_a2", wq_addr[2], 128); chk("t2_d2", wq_data[2], 32'h00C0C0C0);
            chk("t2_a3", wq_addr[3], 129); chk("t2_d3", wq_data[3], 32'h00D0D0D0);
            chk("t2_wr_first", wq_cyc[0] - s, 3);
            chk("t2_wr_last", wq_cyc[3] - s, 6);
        end
        chk("t2_done_at", done_cyc - s, 7);
        chk("t2_busy_first", busy_first - s, 1);
        chk("t2_busy_last", busy_last - s, 6);

        // gapped 3x1 at (3,1)
        clear_log();
        for (int i = 0; i < 3; i++) pix[i] = 32'h00010203 + 32'(i);
        do_start(3, 1, 3, 1, 0);
        stream(3, 1, -1, -1);
        wait_idle();
        chk("t3_nwr", wq_addr.size(), 3);
        if (wq_addr.size() == 3) begin
            chk("t3_a0", wq_addr[0], 131);
            chk("t3_a2", wq_addr[2], 133);
            chk("t3_gap", wq_cyc[1] - wq_cyc[0], 2);
        end

        // key skip
        clear_log();
        d0 = done_cnt;
        pix[0] = KEY; pix[1] = 32'h00112233;
        do_start(10, 0, 2, 1, 1);
        stream(2, 0, -1, -1);
        wait_idle();
        chk("t4_nwr", wq_addr.size(), 1);
        if (wq_addr.size() == 1) begin
            chk("t4_addr", wq_addr[0], 11);
            chk("t4_data", wq_data[0], 32'h00112233);
        end
        chk("t4_done", done_cnt - d0, 1);

        // rejected starts
        clear_log();
        e0 = err_cnt; d0 = done_cnt;
        do_start(0, 0, 0, 1, 0);   wait_idle();
        do_start(120, 0, 9, 1, 0); wait_idle();
        do_start(0, 255, 1, 2, 0); wait_idle();
        chk("t5_err_cnt", err_cnt - e0, 3);
        chk("t5_no_wr", wq_addr.size(), 0);
        chk("t5_no_done", done_cnt - d0, 0);
        clear_log();
        for (int i = 0; i < 128; i++) pix[i] = $urandom & 32'h00FFFFFF;
        do_start(0, 255, 128, 1, 0);
        stream(128, 2, -1, -1);
        wait_idle();
        chk("t5_full_nwr", wq_addr.size(), 128);
        if (wq_addr.size() == 128) begin
            chk("t5_first", wq_addr[0], 32640);
            chk("t5_last", wq_addr[127], 32767);
        end

        // start during RUN ignored
        clear_log();
        e0 = err_cnt;
        for (int i = 0; i < 8; i++) pix[i] = 32'h00300000 + 32'(i);
        do_start(5, 2, 4, 2, 0);
        stream(8, 0, -1, 2);
        wait_idle();
        chk("t6_nwr", wq_addr.size(), 8);
        if (wq_addr.size() == 8) begin
            chk("t6_a0", wq_addr[0], 261);
            chk("t6_a7", wq_addr[7], 392);
        end
        chk("t6_no_err", err_cnt - e0, 0);

        // reset mid-RUN after 3 of 6 beats
        clear_log();
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) pix[i] = 32'h00440000 + 32'(i);
        do_start(0, 0, 3, 2, 0);
        stream(6, 0, 3, -1);
        @(posedge clk);
        #2;
        chk("t1_we_before", we, 1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        #1;
        chk("t1_we", we, 0);
        chk("t1_busy", busy, 0);
        chk("t1_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (8) @(negedge clk);
        chk("t1_no_done", done_cnt - d0, 0);
        chk("t1_no_wr", wq_addr.size(), 0);
        pix[0] = 32'h00777777;
        do_start(7, 7, 1, 1, 0);
        stream(1, 0, -1, -1);
        wait_idle();
        chk("t1_restart_done", done_cnt - d0, 1);
        chk("t1_restart_nwr", wq_addr.size(), 1);
        if (wq_addr.size() == 1) chk("t1_restart_addr", wq_addr[0], 903);

        // randomized rectangles, model-checked every cycle
        for (int r = 0; r < 30; r++) begin
            int ox, oy, w, h, sel;
            ox = $urandom_range(0, 127);
            oy = $urandom_range(0, 255);
            w  = $urandom_range(1, 6);
            h  = $urandom_range(1, 4);
            sel = $urandom_range(0, 5);
            if (sel == 0) w = 0;
            if (sel == 1) begin oy = 255; h = 2; end
            for (int i = 0; i < 24; i++)
                pix[i] = ($urandom_range(0, 3) == 0) ? KEY : ($urandom & 32'h00FFFFFF);
            do_start(ox, oy, w, h, 1'($urandom_range(0, 1)));
            if (req_valid(ox, oy, w, h)) stream(w * h, 2, -1, -1);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_ram_writer.md
Name: sprite_ram_writer

Overview:
Loads a rectangular sprite into the sprite memory that the color mapper reads. It accepts a row-major pixel stream over a valid/ready handshake and generates the write addresses. The address layout matches the mapper's read side: addr = PITCH*y + x. It sits between the sprite source (SD/USB loader or NIOS bridge) and the write port of the dual-port sprite RAM.

Parameters:
ADDR_W, 15, sprite RAM address width (2^15 words).
DATA_W, 32, pixel word width, 0x00RRGGBB.
PITCH, 128, words per RAM row; power of two.
KEY, 32'h00FF0000, transparency key colour.

Ports:
Clk  in  1  system clock, rising edge.
Reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle load request; sampled only in IDLE.
org_x  in  10  rectangle origin column; sampled with start.
org_y  in  10  rectangle origin row; sampled with start.
width  in  10  rectangle width in pixels; sampled with start.
height  in  10  rectangle height in pixels; sampled with start.
skip_key  in  1  1 = do not write pixels equal to KEY; sampled with start.
in_data  in  DATA_W  pixel word.
in_valid  in  1  in_data valid.
in_ready  out  1  block accepts a pixel this cycle.
we  out  1  RAM write enable.
waddr  out  ADDR_W  RAM write address.
wdata  out  DATA_W  RAM write data.
busy  out  1  transfer in progress.
done  out  1  one-cycle pulse after the last pixel is written.
err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (Reset_n low, asynchronous): state=IDLE. in_ready, we, busy, done, err = 0. waddr=0, wdata=0. col/row counters=0. Reset mid-transfer aborts the transfer; no further writes occur and no done pulse is issued.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE, start=1: validate the request.
  - Reject if width==0, height==0, org_x+width>PITCH, or PITCH*(org_y+height-1)+org_x+width-1 > 2^ADDR_W-1.
  - Reject action: err=1 for exactly one cycle; remain in IDLE.
  - Otherwise: latch all parameters, col=row=0, base=PITCH*org_y+org_x, go to RUN.
  - Validation arithmetic uses at least 21-bit unsigned intermediates; no truncation before comparison.
- RUN:
  - in_ready=1 and busy=1. A beat is accepted when in_valid && in_ready.
  - On a beat: col increments. When col==width-1, col returns to 0, row increments, and base increases by PITCH.
  - After the beat with col==width-1 and row==height-1: in_ready deasserts in the next cycle; go to FLUSH.
  - No beat: counters hold and no write is issued.
- Write pipeline: registered, latency 1 cycle.
  - Beat accepted in cycle N gives, in cycle N+1: we=1, waddr=base+col (values from cycle N, truncated to ADDR_W), wdata=in_data.
  - Exception: when skip_key=1 and in_data==KEY, we=0 in N+1; addressing still advances.
  - we=0 in every cycle with no preceding accepted beat.
- FLUSH: lasts one cycle, in which the final write is visible on we/waddr/wdata. busy=1. Then go to DONE.
- DONE: done=1 for one cycle, busy=0; then go to IDLE.
  - Start cycle to done: at least width*height+3 cycles.
- start outside IDLE is ignored; err is not pulsed.
- in_data with in_ready=0 is ignored.
- Register reads of the RAM by the color mapper are unaffected by this block (separate port).

Test Plan:
1. Reset_n low mid-RUN after 3 of 6 beats -> we, busy, in_ready drop to 0 immediately. After release: no done pulse, and a new start is accepted.
2. start with org=(0,0), size 2x2, stream A,B,C,D continuously -> writes (0,A),(1,B),(128,C),(129,D) on 4 consecutive cycles. done pulses at start+7. busy is high from start+1 to start+6.
3. start with org=(3,1), size 3x1, in_valid gapped 1-0-1-0-1 -> writes at 131,132,133 only in cycles after accepted beats. No write during gaps.
4. skip_key=1, 2x1 at (10,0), stream KEY, 0x00112233 -> a single write (11, 0x00112233). Address 10 is not written. done still pulses.
5. Rejected starts:
   - width=0 -> err pulse, busy stays 0.
   - org_x=120, width=9 -> err.
   - org_y=255, height=2 (address 32768 > 32767) -> err.
   - org_y=255, height=1, org_x=0, width=128 -> accepted; last waddr=32767.
6. start pulsed again while in RUN with different org -> ignored. Original addresses continue and err stays 0.
